exins_responder: RTL and testbench
==================================

# exins_responder

External-instruction responder for the core's `exIns_*` fetch port. The core raises `exIns_ren` with a byte address on `exIns_addr`; this block looks the word up in an internal instruction store and returns it on `exIns_in`, qualified by a one-cycle `exIns_valid` pulse, after a fixed configurable latency. A word-write loader port fills the store, and a post-reset init sequence pre-fills it with NOPs. The block sits beside `core` in the system top, as the far end of the core's external instruction interface.

## Interface
- `MEM_WORDS`, 256: instruction store depth in 32-bit words; power of two, 16..4096.
- `LATENCY`, 2: request-to-response delay in cycles; 1..8.
- `NOP_WORD`, 32'h0000_0013: fill value and substitute response for invalid requests.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `exIns_ren`  in  1  read request from core; one request per cycle when high.
- `exIns_addr`  in  32  byte address of the requested instruction.
- `exIns_valid`  out  1  response strobe; high for exactly one cycle per accepted request.
- `exIns_in`  out  32  response data; meaningful only while `exIns_valid` is high.
- `ld_we`  in  1  loader write enable.
- `ld_addr`  in  log2(MEM_WORDS)  loader word index.
- `ld_data`  in  32  loader write data.
- `ready`  out  1  init sequence done; store contents valid.
- `err_addr`  out  1  sticky: a misaligned or out-of-range request was seen.
- `err_init`  out  1  sticky: a request arrived while `ready` was low.
- `req_cnt`  out  16  accepted-request count; wraps modulo 2^16.

## Operation
- States: INIT, RUN. Reset enters INIT with init pointer 0.
- INIT: each cycle writes `NOP_WORD` to the store at the pointer and increments the pointer. After the write to index `MEM_WORDS-1`, the state moves to RUN and `ready` goes high. Total INIT duration is `MEM_WORDS` cycles.
- `ld_we` is ignored in INIT. In RUN it writes `ld_data` to `ld_addr` at the clock edge.
- Request acceptance: every cycle with `exIns_ren` high is accepted, in either state. There is no backpressure. `req_cnt` increments by 1 per accepted request.
- Word index is `exIns_addr[31:2]`.
- Invalid request: `exIns_addr[1:0] != 0` or index `>= MEM_WORDS`. The response data is `NOP_WORD` and `err_addr` is set.
- Request accepted in INIT: the response data is `NOP_WORD` and `err_init` is set. If the request is also invalid, both flags are set.
- Valid request in RUN: the response data is the store word at the index.
- Loader collision: `ld_we` in RUN with `ld_addr` equal to the index of a same-cycle request returns the new `ld_data` (write-first).
- Response pipeline: a LATENCY-stage shift register of {valid, data}. Responses return in request order. Back-to-back requests give back-to-back responses.
- Sticky flags clear only on `rst`.

## Timing
- Reset values: `exIns_valid`=0, `exIns_in`=0, `ready`=0, `err_addr`=0, `err_init`=0, `req_cnt`=0. State INIT, pointer 0, pipeline empty.
- A request sampled at rising edge N produces `exIns_valid`=1 and its data in the cycle after edge N+LATENCY-1. With LATENCY=1, the response is visible in the cycle following the sampling edge.
- `exIns_in` holds its last value when `exIns_valid` is low.
- `ready` rises in the cycle after the edge that performs the write to index `MEM_WORDS-1`, i.e. `MEM_WORDS` edges after reset deassertion.
- `rst` asserted mid-stream: all outputs go to their reset values immediately (asynchronously). In-flight responses are dropped, not delivered later. INIT restarts from index 0. Store contents are re-filled, so loader data is lost.
- `req_cnt` at 16'hFFFF plus one request gives 16'h0000, with no flag raised.
- Store read and loader write are single-cycle; the store is a synchronous-write array with a combinational read into pipeline stage 1.

## Test plan
- Init: release `rst`, MEM_WORDS=256. `ready`=0 for 256 cycles, then `ready`=1; a read of address 0x0000_0040 returns 0x0000_0013, with `err_*`=0.
- Load and stream: write 0x0000_0093 to index 0 and 0x0010_0113 to index 1. Issue `ren` at addr 0x0, 0x4, 0x0 on consecutive cycles with LATENCY=2. Responses are 0x0000_0093, 0x0010_0113, 0x0000_0093 on three consecutive cycles, starting 2 edges after the first request. `req_cnt`=3.
- Invalid addresses: request 0x0000_0002, then 0x0000_0400 (index 256). Both responses are 0x0000_0013 and `err_addr`=1. The flag stays 1 after subsequent valid reads.
- Early request: `ren` at addr 0x0 during INIT gives a response of 0x0000_0013 after LATENCY cycles and `err_init`=1.
- Collision: in RUN, `ld_we` with index 5, data 0xDEAD_BEEF, in the same cycle as `ren` at addr 0x14. The response is 0xDEAD_BEEF.
- Reset mid-flight: with LATENCY=4, issue 2 requests, then pulse `rst` 2 cycles later. No `exIns_valid` appears afterward, `req_cnt`=0, `ready`=0, and INIT re-runs for `MEM_WORDS` cycles.

Source files
------------

// File: rtl/exins_responder.sv
// External-instruction responder: answers exIns_* fetch requests from an internal
// instruction store after a fixed latency; store is NOP-filled after reset and loadable.
module exins_responder #(
   parameter int unsigned MEM_WORDS = 256,
   parameter int unsigned LATENCY   = 2,
   parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         exIns_ren,
   input  logic [31:0]                  exIns_addr,
   output logic                         exIns_valid,
   output logic [31:0]                  exIns_in,
   input  logic                         ld_we,
   input  logic [$clog2(MEM_WORDS)-1:0] ld_addr,
   input  logic [31:0]                  ld_data,
   output logic                         ready,
   output logic                         err_addr,
   output logic                         err_init,
   output logic [15:0]                  req_cnt
);

   localparam int unsigned AW = $clog2(MEM_WORDS);

   typedef enum logic [0:0] {S_INIT = 1'b0, S_RUN = 1'b1} state_e;

   state_e            state;
   state_e            state_next;
   logic              init_we_c;
   logic              run_c;
   logic [AW-1:0]     ptr;
   logic [31:0]       mem [MEM_WORDS];

   logic [29:0]       req_idx_c;
   logic              req_bad_c;
   logic [31:0]       req_data_c;

   logic              pipe_v [LATENCY];
   logic [31:0]       pipe_d [LATENCY];

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_INIT;
      else     state <= state_next;
   end

   // Next state: leave INIT after the fill write to the last index
   always_comb begin
      state_next = state;
      case (state)
         S_INIT:  if (ptr == AW'(MEM_WORDS - 1)) state_next = S_RUN;
         S_RUN:   state_next = S_RUN;
         default: state_next = S_INIT;
      endcase
   end

   always_comb begin
      init_we_c = 1'b0;
      run_c     = 1'b0;
      case (state)
         S_INIT:  init_we_c = 1'b1;
         S_RUN:   run_c     = 1'b1;
         default: init_we_c = 1'b1;
      endcase
   end

   // Instruction store: synchronous write, combinational read
   always_ff @(posedge clk) begin
      if (init_we_c)          mem[ptr]     <= NOP_WORD;
      else if (run_c && ld_we) mem[ld_addr] <= ld_data;
   end

   // Request lookup; loader write-through gives write-first collision behaviour
   always_comb begin
      req_idx_c  = exIns_addr[31:2];
      req_bad_c  = (exIns_addr[1:0] != 2'b00) || (req_idx_c >= 30'(MEM_WORDS));
      req_data_c = NOP_WORD;
      if (run_c && !req_bad_c) begin
         if (ld_we && (ld_addr == req_idx_c[AW-1:0])) req_data_c = ld_data;
         else                                          req_data_c = mem[req_idx_c[AW-1:0]];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr      <= '0;
         ready    <= 1'b0;
         err_addr <= 1'b0;
         err_init <= 1'b0;
         req_cnt  <= '0;
      end else begin
         if (init_we_c) ptr <= ptr + AW'(1);
         ready <= (state_next == S_RUN);
         if (exIns_ren) begin
            req_cnt <= req_cnt + 16'd1;
            if (req_bad_c) err_addr <= 1'b1;
            if (!run_c)    err_init <= 1'b1;
         end
      end
   end

   // Response pipeline; data stages only load behind a valid so the output holds
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(LATENCY); i++) begin
            pipe_v[i] <= 1'b0;
            pipe_d[i] <= '0;
         end
      end else begin
         pipe_v[0] <= exIns_ren;
         if (exIns_ren) pipe_d[0] <= req_data_c;
         for (int i = 1; i < int'(LATENCY); i++) begin
            pipe_v[i] <= pipe_v[i-1];
            if (pipe_v[i-1]) pipe_d[i] <= pipe_d[i-1];
         end
      end
   end

   assign exIns_valid = pipe_v[LATENCY-1];
   assign exIns_in    = pipe_d[LATENCY-1];

endmodule

// File: tb/tb_exins_responder.sv
// Scoreboard bench for exins_responder: a 256-word/latency-2 instance for data paths,
// and a 16-word/latency-4 instance for the mid-flight reset case.
module tb_exins_responder;

   localparam int unsigned LAT  = 2;
   localparam int unsigned LAT4 = 4;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   typedef struct {
      int unsigned due;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, exIns_ren, ld_we;
   logic [31:0] exIns_addr, ld_data, exIns_in;
   logic [7:0]  ld_addr;
   logic        exIns_valid, ready, err_addr, err_init;
   logic [15:0] req_cnt;

   logic        rst4, ren4, ld_we4;
   logic [31:0] addr4, ld_data4, in4;
   logic [3:0]  ld_addr4;
   logic        valid4, ready4, err_addr4, err_init4;
   logic [15:0] req_cnt4;

   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          v4_cnt = 0;
   int          exp_cnt = 0;
   exp_t        exp_q[$];

   exins_responder #(.MEM_WORDS(256), .LATENCY(LAT), .NOP_WORD(NOP)) u_dut (
      .clk(clk), .rst(rst), .exIns_ren(exIns_ren), .exIns_addr(exIns_addr),
      .exIns_valid(exIns_valid), .exIns_in(exIns_in), .ld_we(ld_we), .ld_addr(ld_addr),
      .ld_data(ld_data), .ready(ready), .err_addr(err_addr), .err_init(err_init),
      .req_cnt(req_cnt));

   exins_responder #(.MEM_WORDS(16), .LATENCY(LAT4), .NOP_WORD(NOP)) u_dut4 (
      .clk(clk), .rst(rst4), .exIns_ren(ren4), .exIns_addr(addr4),
      .exIns_valid(valid4), .exIns_in(in4), .ld_we(ld_we4), .ld_addr(ld_addr4),
      .ld_data(ld_data4), .ready(ready4), .err_addr(err_addr4), .err_init(err_init4),
      .req_cnt(req_cnt4));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Monitor: pops the scoreboard on every response, flags late or unexpected ones
   always @(negedge clk) begin
      exp_t e;
      if (exIns_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("resp_data", exIns_in, e.data);
            check("resp_cycle", 32'(cyc), 32'(e.due));
         end
      end else if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
         e = exp_q.pop_front();
         check("missing_valid", 32'd0, 32'd1);
      end
   end

   always @(negedge clk) if (valid4) v4_cnt <= v4_cnt + 1;

   // One request cycle, called at a falling edge
   task automatic issue(input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      e.due  = cyc + LAT;
      e.data = d;
      exp_q.push_back(e);
      exp_cnt++;
      exIns_ren  = 1'b1;
      exIns_addr = a;
      @(negedge clk);
      exIns_ren  = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         check("drain_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic load(input logic [7:0] a, input logic [31:0] d);
      ld_we   = 1'b1;
      ld_addr = a;
      ld_data = d;
      @(negedge clk);
      ld_we   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1'b1; exIns_ren = 1'b0; exIns_addr = '0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
      rst4 = 1'b1; ren4 = 1'b0; addr4 = '0; ld_we4 = 1'b0; ld_addr4 = '0; ld_data4 = '0;
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(exIns_valid), 32'd0);
      check("rst_in", exIns_in, 32'd0);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_err_addr", 32'(err_addr), 32'd0);
      check("rst_err_init", 32'(err_init), 32'd0);
      check("rst_req_cnt", 32'(req_cnt), 32'd0);

      // Init fill takes exactly MEM_WORDS edges
      rst = 1'b0;
      n = 0;
      while (!ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("init_cycles", 32'(n), 32'd256);
      issue(32'h0000_0040, NOP);
      drain();
      check("init_err_addr", 32'(err_addr), 32'd0);
      check("init_err_init", 32'(err_init), 32'd0);

      // Load and stream back-to-back
      load(8'd0, 32'h0000_0093);
      load(8'd1, 32'h0010_0113);
      issue(32'h0, 32'h0000_0093);
      issue(32'h4, 32'h0010_0113);
      issue(32'h0, 32'h0000_0093);
      drain();
      check("stream_req_cnt", 32'(req_cnt), 32'(exp_cnt));
      check("hold_valid", 32'(exIns_valid), 32'd0);
      check("hold_in", exIns_in, 32'h0000_0093);

      // Misaligned, out-of-range, and highest valid index
      issue(32'h0000_0002, NOP);
      issue(32'h0000_0400, NOP);
      issue(32'h0000_03FC, NOP);
      drain();
      check("bad_err_addr", 32'(err_addr), 32'd1);
      issue(32'h4, 32'h0010_0113);
      drain();
      check("sticky_err_addr", 32'(err_addr), 32'd1);
      check("run_err_init", 32'(err_init), 32'd0);

      // Loader collision is write-first; later read sees the stored word
      ld_we = 1'b1; ld_addr = 8'd5; ld_data = 32'hDEAD_BEEF;
      issue(32'h14, 32'hDEAD_BEEF);
      ld_we = 1'b0;
      issue(32'h14, 32'hDEAD_BEEF);
      issue(32'h18, NOP);
      drain();
      check("coll_req_cnt", 32'(req_cnt), 32'(exp_cnt));

      // Reset clears everything asynchronously; request during INIT
      rst = 1'b1;
      #1;
      check("rerst_ready", 32'(ready), 32'd0);
      check("rerst_err_addr", 32'(err_addr), 32'd0);
      check("rerst_req_cnt", 32'(req_cnt), 32'd0);
      exp_cnt = 0;
      @(negedge clk);
      rst = 1'b0;
      issue(32'h0, NOP);
      drain();
      check("early_err_init", 32'(err_init), 32'd1);
      check("early_err_addr", 32'(err_addr), 32'd0);
      check("early_ready", 32'(ready), 32'd0);
      check("early_req_cnt", 32'(req_cnt), 32'd1);

      // Latency-4 instance: reset drops in-flight responses
      rst4 = 1'b0;
      n = 0;
      while (!ready4 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("init4_cycles", 32'(n), 32'd16);
      ren4 = 1'b1; addr4 = 32'h0;
      @(negedge clk);
      addr4 = 32'h4;
      @(negedge clk);
      ren4 = 1'b0;
      check("l4_req_cnt", 32'(req_cnt4), 32'd2);
      @(negedge clk);
      check("l4_no_early_valid", 32'(v4_cnt), 32'd0);
      rst4 = 1'b1;
      #1;
      check("l4_rst_valid", 32'(valid4), 32'd0);
      check("l4_rst_req_cnt", 32'(req_cnt4), 32'd0);
      check("l4_rst_ready", 32'(ready4), 32'd0);
      @(negedge clk);
      rst4 = 1'b0;
      n = 0;
      while (!ready4 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("reinit4_cycles", 32'(n), 32'd16);
      check("l4_dropped", 32'(v4_cnt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
